// File: rtl/i2c_slave_rx_if.sv
// Bus-side signal bundle for the write-only I2C target receiver.
// The master modport is the bus/test side; the slave modport is the receiver.
interface i2c_slave_rx_if;
    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] data_out;
    logic       data_valid;
    logic       addr_match;
    logic       busy;
    logic       stop_det;

    modport slave (
        input  scl,
        input  sda_in,
        output sda_oe,
        output data_out,
        output data_valid,
        output addr_match,
        output busy,
        output stop_det
    );

    modport master (
        output scl,
        output sda_in,
        input  sda_oe,
        input  data_out,
        input  data_valid,
        input  addr_match,
        input  busy,
        input  stop_det
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: oversampled START/STOP detection, address match, byte deserialiser.
// Optional I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter on scl and sda.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'b1010101,
    parameter int         SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           reset,
    i2c_slave_rx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_p0;
    logic [SYNC_STAGES-1:0] sda_sync_p0;
    logic                   scl_lvl;
    logic                   sda_lvl;
    logic                   scl_prev_p1;
    logic                   sda_prev_p1;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_ev;
    logic                   stop_ev;

    state_t                 state;
    logic [3:0]             bit_cnt;
    logic [7:0]             shreg;

    // Stage p0: synchronisers; idle bus level is high so reset to 1 avoids phantom edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_p0 <= '1;
            sda_sync_p0 <= '1;
        end else begin
            scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], bus.scl};
            sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], bus.sda_in};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] scl_win_p1;
    logic [2:0] sda_win_p1;

    function automatic logic maj3(input logic [2:0] w);
        return (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
    endfunction

    // Stage p1 (filter): a level needs two of the last three samples to pass
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_win_p1 <= '1;
            sda_win_p1 <= '1;
        end else begin
            scl_win_p1 <= {scl_win_p1[1:0], scl_sync_p0[SYNC_STAGES-1]};
            sda_win_p1 <= {sda_win_p1[1:0], sda_sync_p0[SYNC_STAGES-1]};
        end
    end

    assign scl_lvl = maj3(scl_win_p1);
    assign sda_lvl = maj3(sda_win_p1);
`else
    assign scl_lvl = scl_sync_p0[SYNC_STAGES-1];
    assign sda_lvl = sda_sync_p0[SYNC_STAGES-1];
`endif

    // Stage p1: previous-level flops for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_prev_p1 <= 1'b1;
            sda_prev_p1 <= 1'b1;
        end else begin
            scl_prev_p1 <= scl_lvl;
            sda_prev_p1 <= sda_lvl;
        end
    end

    assign scl_rise = scl_lvl & ~scl_prev_p1;
    assign scl_fall = ~scl_lvl & scl_prev_p1;
    assign start_ev = scl_lvl & sda_prev_p1 & ~sda_lvl;
    assign stop_ev  = scl_lvl & ~sda_prev_p1 & sda_lvl;

    // Stage p2: protocol FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            bit_cnt        <= 4'd0;
            shreg          <= 8'h00;
            bus.sda_oe     <= 1'b0;
            bus.data_out   <= 8'h00;
            bus.data_valid <= 1'b0;
            bus.addr_match <= 1'b0;
            bus.busy       <= 1'b0;
            bus.stop_det   <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            bus.stop_det   <= 1'b0;

            if (stop_ev) begin
                state          <= IDLE;
                bit_cnt        <= 4'd0;
                bus.sda_oe     <= 1'b0;
                bus.addr_match <= 1'b0;
                bus.busy       <= 1'b0;
                bus.stop_det   <= 1'b1;
            end else if (start_ev) begin
                // Covers both first and repeated START; any ACK drive is dropped at once
                state          <= ADDR;
                bit_cnt        <= 4'd0;
                bus.sda_oe     <= 1'b0;
                bus.addr_match <= 1'b0;
                bus.busy       <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;

                    ADDR: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shreg   <= {shreg[6:0], sda_lvl};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shreg[7:1] == SLAVE_ADDR && !shreg[0]) begin
                                state          <= ADDR_ACK;
                                bus.sda_oe     <= 1'b1;
                                bus.addr_match <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            state      <= DATA;
                            bus.sda_oe <= 1'b0;
                            bit_cnt    <= 4'd0;
                        end
                    end

                    DATA: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shreg   <= {shreg[6:0], sda_lvl};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bus.data_out   <= {shreg[6:0], sda_lvl};
                                bus.data_valid <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            state      <= DATA_ACK;
                            bus.sda_oe <= 1'b1;
                        end
                    end

                    DATA_ACK: begin
                        if (scl_fall) begin
                            state      <= DATA;
                            bus.sda_oe <= 1'b0;
                            bit_cnt    <= 4'd0;
                        end
                    end

                    IGNORE: ;

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: bit-banged I2C master with open-drain sda
// and pulse monitors on the strobe outputs.
module tb_i2c_slave_rx;

    localparam int Q = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scl_drv = 1'b1;
    logic sda_drv = 1'b1;

    int vecs = 0;
    int errs = 0;

    int dv_cnt = 0;
    int sd_cnt = 0;
    int oe_cnt = 0;
    logic [7:0] dv_last = 8'h00;
    logic [7:0] dv_prev = 8'h00;

    i2c_slave_rx_if bus ();

    assign bus.scl    = scl_drv;
    assign bus.sda_in = sda_drv & ~bus.sda_oe;

    i2c_slave_rx #(
        .SLAVE_ADDR (7'b1010101),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            dv_cnt  <= dv_cnt + 1;
            dv_prev <= dv_last;
            dv_last <= bus.data_out;
        end
        if (bus.stop_det === 1'b1) sd_cnt <= sd_cnt + 1;
        if (bus.sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wclk(Q);
        scl_drv = 1'b1; wclk(Q);
        sda_drv = 1'b0; wclk(Q);
        scl_drv = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wclk(Q);
        scl_drv = 1'b1; wclk(Q);
        sda_drv = 1'b1; wclk(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sda_drv = b[7-i]; wclk(Q);
            scl_drv = 1'b1;   wclk(Q);
            scl_drv = 1'b0;   wclk(Q);
        end
    endtask

    task automatic ack_slot(output logic oe);
        sda_drv = 1'b1; wclk(Q);
        scl_drv = 1'b1; wclk(Q / 2);
        oe = bus.sda_oe;
        wclk(Q / 2);
        scl_drv = 1'b0; wclk(Q);
    endtask

    task automatic test_reset();
        wclk(4);
        if (bus.sda_oe !== 1'b0) begin errs++; $display("FAIL reset_sda_oe: got %b want 0", bus.sda_oe); end
        vecs++;
        if (bus.data_out !== 8'h00) begin errs++; $display("FAIL reset_data_out: got %h want 00", bus.data_out); end
        vecs++;
        if ({bus.data_valid, bus.addr_match, bus.busy, bus.stop_det} !== 4'b0000) begin
            errs++; $display("FAIL reset_flags: got %b want 0000", {bus.data_valid, bus.addr_match, bus.busy, bus.stop_det});
        end
        vecs++;
        reset = 1'b0;
        wclk(10);
        if (bus.busy !== 1'b0) begin errs++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
        vecs++;
    endtask

    task automatic test_basic_write();
        int dv0, sd0;
        logic oe;
        dv0 = dv_cnt; sd0 = sd_cnt;
        i2c_start();
        if (bus.busy !== 1'b1) begin errs++; $display("FAIL basic_busy_start: got %b want 1", bus.busy); end
        vecs++;
        send_bits(8'hAA, 8);
        ack_slot(oe);
        if (oe !== 1'b1) begin errs++; $display("FAIL basic_addr_ack: got %b want 1", oe); end
        vecs++;
        if (bus.addr_match !== 1'b1) begin errs++; $display("FAIL basic_addr_match: got %b want 1", bus.addr_match); end
        vecs++;
        send_bits(8'hB8, 8);
        ack_slot(oe);
        if (oe !== 1'b1) begin errs++; $display("FAIL basic_data_ack: got %b want 1", oe); end
        vecs++;
        if (dv_cnt - dv0 !== 1) begin errs++; $display("FAIL basic_dv_count: got %0d want 1", dv_cnt - dv0); end
        vecs++;
        if (bus.data_out !== 8'hB8) begin errs++; $display("FAIL basic_data_out: got %h want b8", bus.data_out); end
        vecs++;
        i2c_stop();
        if (sd_cnt - sd0 !== 1) begin errs++; $display("FAIL basic_stop_det: got %0d want 1", sd_cnt - sd0); end
        vecs++;
        if ({bus.busy, bus.addr_match} !== 2'b00) begin
            errs++; $display("FAIL basic_end_flags: got %b want 00", {bus.busy, bus.addr_match});
        end
        vecs++;
    endtask

    task automatic test_wrong_addr();
        int dv0, oe0;
        logic oe;
        dv0 = dv_cnt; oe0 = oe_cnt;
        i2c_start();
        send_bits(8'hA8, 8);
        ack_slot(oe);
        if (oe !== 1'b0) begin errs++; $display("FAIL wrong_addr_ack: got %b want 0", oe); end
        vecs++;
        send_bits(8'hBB, 8);
        ack_slot(oe);
        if (bus.busy !== 1'b1) begin errs++; $display("FAIL wrong_addr_busy: got %b want 1", bus.busy); end
        vecs++;
        if (bus.addr_match !== 1'b0) begin errs++; $display("FAIL wrong_addr_match: got %b want 0", bus.addr_match); end
        vecs++;
        if (oe_cnt !== oe0) begin errs++; $display("FAIL wrong_addr_oe_cycles: got %0d want 0", oe_cnt - oe0); end
        vecs++;
        if (dv_cnt !== dv0) begin errs++; $display("FAIL wrong_addr_dv: got %0d want 0", dv_cnt - dv0); end
        vecs++;
        i2c_stop();
        if (bus.busy !== 1'b0) begin errs++; $display("FAIL wrong_addr_busy_end: got %b want 0", bus.busy); end
        vecs++;
    endtask

    task automatic test_read_nack();
        int dv0, sd0, oe0;
        logic oe;
        dv0 = dv_cnt; sd0 = sd_cnt; oe0 = oe_cnt;
        i2c_start();
        send_bits(8'hAB, 8);
        ack_slot(oe);
        if (oe !== 1'b0) begin errs++; $display("FAIL read_nack: got %b want 0", oe); end
        vecs++;
        send_bits(8'h55, 8);
        ack_slot(oe);
        if ({bus.busy, bus.addr_match} !== 2'b10) begin
            errs++; $display("FAIL read_ignore_flags: got %b want 10", {bus.busy, bus.addr_match});
        end
        vecs++;
        if (oe_cnt !== oe0 || dv_cnt !== dv0) begin
            errs++; $display("FAIL read_ignore_quiet: got oe=%0d dv=%0d want 0 0", oe_cnt - oe0, dv_cnt - dv0);
        end
        vecs++;
        i2c_stop();
        if (sd_cnt - sd0 !== 1 || bus.busy !== 1'b0) begin
            errs++; $display("FAIL read_stop: got stops=%0d busy=%b want 1 0", sd_cnt - sd0, bus.busy);
        end
        vecs++;
    endtask

    task automatic test_back_to_back();
        int dv0, acks;
        logic oe;
        dv0 = dv_cnt; acks = 0;
        i2c_start();
        send_bits(8'hAA, 8); ack_slot(oe); if (oe === 1'b1) acks++;
        send_bits(8'hB8, 8); ack_slot(oe); if (oe === 1'b1) acks++;
        send_bits(8'hBB, 8); ack_slot(oe); if (oe === 1'b1) acks++;
        if (acks !== 3) begin errs++; $display("FAIL b2b_acks: got %0d want 3", acks); end
        vecs++;
        if (dv_cnt - dv0 !== 2) begin errs++; $display("FAIL b2b_dv_count: got %0d want 2", dv_cnt - dv0); end
        vecs++;
        if (dv_prev !== 8'hB8 || dv_last !== 8'hBB) begin
            errs++; $display("FAIL b2b_bytes: got %h %h want b8 bb", dv_prev, dv_last);
        end
        vecs++;
        i2c_stop();
    endtask

    task automatic test_stop_rstart();
        int dv0, sd0;
        logic oe;
        dv0 = dv_cnt; sd0 = sd_cnt;
        i2c_start();
        send_bits(8'hAA, 8); ack_slot(oe);
        send_bits(8'hF0, 4);
        i2c_stop();
        if (dv_cnt !== dv0) begin errs++; $display("FAIL partial_dv: got %0d want 0", dv_cnt - dv0); end
        vecs++;
        if (sd_cnt - sd0 !== 1 || {bus.busy, bus.addr_match} !== 2'b00) begin
            errs++; $display("FAIL partial_stop: got stops=%0d flags=%b want 1 00", sd_cnt - sd0, {bus.busy, bus.addr_match});
        end
        vecs++;
        i2c_start();
        send_bits(8'hAA, 8); ack_slot(oe);
        send_bits(8'hC3, 3);
        i2c_start();
        if ({bus.busy, bus.addr_match, bus.sda_oe} !== 3'b100) begin
            errs++; $display("FAIL rstart_flags: got %b want 100", {bus.busy, bus.addr_match, bus.sda_oe});
        end
        vecs++;
        send_bits(8'hAA, 4);
        i2c_start();
        send_bits(8'hAA, 8); ack_slot(oe);
        if (oe !== 1'b1) begin errs++; $display("FAIL rstart_addr_ack: got %b want 1", oe); end
        vecs++;
        send_bits(8'h3C, 8); ack_slot(oe);
        if (dv_cnt - dv0 !== 1 || dv_last !== 8'h3C) begin
            errs++; $display("FAIL rstart_data: got n=%0d byte=%h want 1 3c", dv_cnt - dv0, dv_last);
        end
        vecs++;
        i2c_stop();
    endtask

    task automatic test_reset_in_ack();
        logic oe;
        i2c_start();
        send_bits(8'hAA, 8); ack_slot(oe);
        send_bits(8'hB8, 8);
        if (bus.sda_oe !== 1'b1) begin errs++; $display("FAIL pre_reset_oe: got %b want 1", bus.sda_oe); end
        vecs++;
        #3;
        reset = 1'b1;
        #1;
        if (bus.sda_oe !== 1'b0) begin errs++; $display("FAIL async_reset_oe: got %b want 0", bus.sda_oe); end
        vecs++;
        if (bus.data_out !== 8'h00 || {bus.addr_match, bus.busy, bus.data_valid, bus.stop_det} !== 4'b0000) begin
            errs++; $display("FAIL async_reset_outputs: got %h %b want 00 0000", bus.data_out,
                             {bus.addr_match, bus.busy, bus.data_valid, bus.stop_det});
        end
        vecs++;
        scl_drv = 1'b1; sda_drv = 1'b1;
        wclk(4);
        reset = 1'b0;
        wclk(10);
        i2c_start();
        send_bits(8'hAA, 8); ack_slot(oe);
        if (oe !== 1'b1) begin errs++; $display("FAIL post_reset_ack: got %b want 1", oe); end
        vecs++;
        send_bits(8'h5A, 8); ack_slot(oe);
        if (bus.data_out !== 8'h5A) begin errs++; $display("FAIL post_reset_data: got %h want 5a", bus.data_out); end
        vecs++;
        i2c_stop();
        if (bus.busy !== 1'b0) begin errs++; $display("FAIL post_reset_busy: got %b want 0", bus.busy); end
        vecs++;
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_wrong_addr();
        test_read_nack();
        test_back_to_back();
        test_stop_rstart();
        test_reset_in_ack();
        wclk(5);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
